// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, PC step and the IF/ID payload type.
package riscv_pipe_pkg;

  localparam int unsigned RV_XLEN = 32;
  localparam int unsigned RV_ILEN = 32;

  // addi x0, x0, 0
  localparam logic [RV_ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Sequential fetch advances by one 32-bit instruction
  localparam int unsigned PC_STEP = 4;

  // IF/ID pipeline register payload, also consumed by the decode stage
  typedef struct packed {
    logic               valid;
    logic [RV_XLEN-1:0] pc;
    logic [RV_ILEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks the in-flight fetch response while IF/ID is stalled.
// Ports: clk, rst_n; capture/drain/clear controls (clear > capture > drain);
//        in_pc/in_instr capture data; hold_valid/hold_pc/hold_instr registered contents.
module fetch_hold_buf
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ILEN-1:0] in_instr,
  output logic            hold_valid,
  output logic [XLEN-1:0] hold_pc,
  output logic [ILEN-1:0] hold_instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;

  // Next-state: a clear (redirect) wins so a parked instruction is dropped, never drained
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= ILEN'(NOP_INSTR);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign hold_valid = valid_q;
  assign hold_pc    = pc_q;
  assign hold_instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, drives a 1-cycle-latency instruction memory and the IF/ID register.
// Ports: clk, rst_n; stall_pc/stall_if_id from hazard unit; redirect_valid/redirect_pc from EX;
//        imem_req/imem_addr/imem_rdata to instruction memory; if_id_valid/if_id_pc/if_id_instr.
// Optional: define FETCH_PERF_CNT_EN to add saturating perf_stall_cycles/perf_redirects outputs.
module fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_pc,
  input  logic            stall_if_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_redirects
`endif
);

  logic            stall;
  logic            req;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            f1_valid_q, f1_valid_d;
  logic [XLEN-1:0] f1_pc_q, f1_pc_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [ILEN-1:0] if_id_instr_q, if_id_instr_d;
  logic            hb_capture, hb_drain, hb_clear;
  logic            hb_valid;
  logic [XLEN-1:0] hb_pc;
  logic [ILEN-1:0] hb_instr;

  // Either stall input freezes fetch; gating with rst_n keeps the request low during reset
  assign stall     = stall_pc | stall_if_id;
  assign req       = rst_n & ~stall & ~redirect_valid;
  assign imem_req  = req;
  assign imem_addr = pc_q;

  // PC, in-flight tracking and IF/ID next-state
  always_comb begin
    pc_d          = pc_q;
    f1_valid_d    = req;
    f1_pc_d       = f1_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    hb_capture    = 1'b0;
    hb_drain      = 1'b0;
    hb_clear      = 1'b0;

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end

    if (req) begin
      f1_pc_d = pc_q;
    end

    if (redirect_valid) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = ILEN'(NOP_INSTR);
      hb_clear      = 1'b1;
    end else if (stall) begin
      // Response for the last request lands now; park it so it is not lost
      hb_capture = f1_valid_q;
    end else if (hb_valid) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = hb_pc;
      if_id_instr_d = hb_instr;
      hb_drain      = 1'b1;
    end else if (f1_valid_q) begin
      if_id_valid_d = 1'b1;
      if_id_pc_d    = f1_pc_q;
      if_id_instr_d = imem_rdata;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = ILEN'(NOP_INSTR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      f1_valid_q    <= 1'b0;
      f1_pc_q       <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= ILEN'(NOP_INSTR);
    end else begin
      pc_q          <= pc_d;
      f1_valid_q    <= f1_valid_d;
      f1_pc_q       <= f1_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  fetch_hold_buf #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (hb_capture),
    .drain      (hb_drain),
    .clear      (hb_clear),
    .in_pc      (f1_pc_q),
    .in_instr   (imem_rdata),
    .hold_valid (hb_valid),
    .hold_pc    (hb_pc),
    .hold_instr (hb_instr)
  );

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_redir_q, perf_redir_d;

  // Saturating event counters
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_redir_d = perf_redir_q;
    if (stall && !redirect_valid && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (redirect_valid && (perf_redir_q != 32'hFFFF_FFFF)) begin
      perf_redir_d = perf_redir_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_redir_q <= perf_redir_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stall/redirect traffic
// checked every cycle against an in-order fetch-queue model of the stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] TAG     = 32'hA5A5_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_pc, stall_if_id, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2, imem_rdata, imem_rdata2;
  logic        if_id_valid, if_id_valid2;
  logic [31:0] if_id_pc, if_id_pc2, if_id_instr, if_id_instr2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_redirects, perf_stall2, perf_redir2;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_pc       (stall_pc),
    .stall_if_id    (stall_if_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
`endif
  );

  // Free-running instance with a reset PC near the top of the address space
  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(RST_PC2)) u_dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_pc       (1'b0),
    .stall_if_id    (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .if_id_valid    (if_id_valid2),
    .if_id_pc       (if_id_pc2),
    .if_id_instr    (if_id_instr2)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall2),
    .perf_redirects    (perf_redir2)
`endif
  );

  // Instruction memories: 1-cycle latency, garbage when no request was made
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? (imem_addr  ^ TAG) : $urandom;
    imem_rdata2 <= imem_req2 ? (imem_addr2 ^ TAG) : $urandom;
  end

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // Reference model: expected next fetch address and FIFO of issued, undelivered fetches
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_valid;
  logic [31:0] m_ifpc, m_instr;
  logic [31:0] m_perf_stall, m_perf_redir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_valid = 1'b0;
    m_ifpc = 32'h0;
    m_instr = NOP;
    m_perf_stall = 0;
    m_perf_redir = 0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model at the rising edge
  task automatic cycle(input logic sp, input logic si, input logic rv, input logic [31:0] rp);
    logic st;
    logic [31:0] p;
    st = sp | si;
    stall_pc = sp;
    stall_if_id = si;
    redirect_valid = rv;
    redirect_pc = rp;
    @(negedge clk);
    chk("imem_req", {31'b0, imem_req}, {31'b0, !st && !rv});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("if_id_instr", if_id_instr, m_instr);
    if (m_valid) chk("if_id_pc", if_id_pc, m_ifpc);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cycles, m_perf_stall);
    chk("perf_redir", perf_redirects, m_perf_redir);
`endif
    @(posedge clk);
    if (rv) begin
      m_q.delete();
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!st) begin
      if (m_q.size() > 0) begin
        p = m_q.pop_front();
        m_valid = 1'b1;
        m_ifpc = p;
        m_instr = p ^ TAG;
      end else begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end
    if (rv) m_pc = rp;
    else if (!st) begin
      m_q.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (st && !rv && m_perf_stall != 32'hFFFF_FFFF) m_perf_stall++;
    if (rv && m_perf_redir != 32'hFFFF_FFFF) m_perf_redir++;
    #1;
  endtask

  task automatic expect_ifid(input string name, input logic v, input logic [31:0] pc);
    chk({name, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    if (v) begin
      chk({name, "_pc"}, if_id_pc, pc);
      chk({name, "_instr"}, if_id_instr, pc ^ TAG);
    end else begin
      chk({name, "_instr"}, if_id_instr, NOP);
    end
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0;
    stall_pc = 1'b0;
    stall_if_id = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_id_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_if_id_pc", if_id_pc, 32'h0);
    chk("rst_if_id_instr", if_id_instr, NOP);
    chk("rst_imem_addr2", imem_addr2, RST_PC2);

    // Free run from reset; second instance checks wrap of the PC at the top of memory
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    chk("wrap2_addr_c0", imem_addr2, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("wrap2_addr_c1", imem_addr2, 32'h0000_0000);
    chk("wrap2_ifid_c1", if_id_pc2, RST_PC2);
    expect_ifid("run0", 1, 32'h0);
    cycle(0, 0, 0, 0);
    chk("wrap2_ifid_c2", if_id_pc2, 32'hFFFF_FFFC);
    expect_ifid("run4", 1, 32'h4);
    cycle(0, 0, 0, 0);
    chk("wrap2_ifid_c3", if_id_pc2, 32'h0);
    chk("wrap2_instr_c3", if_id_instr2, TAG);
    cycle(0, 0, 0, 0);
    expect_ifid("pre_stall", 1, 32'hC);

    // Stall 3 cycles with 0x10 in flight
    repeat (3) begin
      cycle(1, 1, 0, 0);
      expect_ifid("stall_hold", 1, 32'hC);
    end
    cycle(0, 0, 0, 0);
    expect_ifid("release", 1, 32'h10);
    cycle(0, 0, 0, 0);
    expect_ifid("release_next", 1, 32'h14);

    // Run up to pc 0x40 then redirect to 0x200
    reached = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_pc == 32'h40) begin reached = 1; break; end
      cycle(0, 0, 0, 0);
    end
    chk("reach_pc40", {31'b0, reached}, 32'h1);
    cycle(0, 0, 1, 32'h200);
    expect_ifid("redir_bubble1", 0, 0);
    cycle(0, 0, 0, 0);
    expect_ifid("redir_bubble2", 0, 0);
    cycle(0, 0, 0, 0);
    expect_ifid("redir_target", 1, 32'h200);
    cycle(0, 0, 0, 0);
    expect_ifid("redir_next", 1, 32'h204);

    // Fill the hold buffer, then redirect during the stall
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 32'h300);
    expect_ifid("hold_redir_b1", 0, 0);
    cycle(0, 0, 0, 0);
    expect_ifid("hold_redir_b2", 0, 0);
    cycle(0, 0, 0, 0);
    expect_ifid("hold_redir_tgt", 1, 32'h300);

    // Wrap on the main instance
    cycle(0, 0, 1, 32'hFFFF_FFF8);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    expect_ifid("wrap_fff8", 1, 32'hFFFF_FFF8);
    cycle(0, 0, 0, 0);
    expect_ifid("wrap_fffc", 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    expect_ifid("wrap_0", 1, 32'h0);

    // Asynchronous reset mid-stall with the hold buffer full
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    #2;
    stall_pc = 1'b0;
    stall_if_id = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_if_id_valid", {31'b0, if_id_valid}, 32'h0);
    chk("arst_if_id_pc", if_id_pc, 32'h0);
    chk("arst_if_id_instr", if_id_instr, NOP);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_perf_stall", perf_stall_cycles, 32'h0);
    chk("arst_perf_redir", perf_redirects, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0);
    expect_ifid("after_rst_b", 0, 0);
    cycle(0, 0, 0, 0);
    expect_ifid("after_rst_0", 1, 32'h0);

    // Random stall / redirect traffic
    for (int i = 0; i < 1500; i++) begin
      logic sp, si, rv;
      logic [31:0] rp;
      int unsigned r;
      r = $urandom_range(0, 99);
      sp = (r < 30);
      si = sp;
      if (r >= 28 && r < 32) begin
        si = ~sp;
      end
      rv = ($urandom_range(0, 99) < 10);
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      cycle(sp, si, rv, rp);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
